axi_lite_mem_slave: RTL
=======================

# axi_lite_mem_slave

- Parametrised AXI-Lite memory slave with DEPTH words of DATA_WDTH bits and per-byte write strobes.
- Serves one transaction at a time: a read (AR→R) or a write (AW→W→B).
- Arbitrates simultaneous AR/AW requests round-robin, with no random choice.
- Returns SLVERR for out-of-range addresses and counts error responses; used as the bus-side memory model behind the sort engine's AXI-Lite master.

## Interface
Parameters:
- ADDR_WDTH, 8, word address width
- DATA_WDTH, 32, data width; multiple of 8
- DEPTH, 16, number of implemented words; 1 ≤ DEPTH ≤ 2^ADDR_WDTH

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- ar_valid  in  1  read address valid
- ar_ready  out  1  read address ready
- ar_address  in  ADDR_WDTH  word address
- r_valid  out  1  read data valid
- r_ready  in  1  read data ready
- r_data  out  DATA_WDTH  read data
- r_resp  out  2  00 = OKAY, 10 = SLVERR
- aw_valid  in  1  write address valid
- aw_ready  out  1  write address ready
- aw_address  in  ADDR_WDTH  word address
- w_valid  in  1  write data valid
- w_ready  out  1  write data ready
- w_data  in  DATA_WDTH  write data
- w_strb  in  DATA_WDTH/8  byte enables
- b_valid  out  1  write response valid
- b_ready  in  1  write response ready
- b_resp  out  2  00 = OKAY, 10 = SLVERR
- force_err  in  1  error injection; used only when ERR_INJECT_EN is defined
- err_count  out  8  saturating count of SLVERR responses delivered

## Operation
States:
- IDLE
- AR_ACC: ar_ready=1
- RD_MEM
- R_RESP: r_valid=1
- AW_ACC: aw_ready=1
- W_WAIT: w_ready=1
- WR_MEM
- B_RESP: b_valid=1

Transitions:
- IDLE: ar_valid only → AR_ACC; aw_valid only → AW_ACC.
- IDLE with both valid: grant the channel opposite to the 1-bit last_grant register, then update last_grant to the granted channel.
- AR_ACC → RD_MEM. The address and error flag (ar_address ≥ DEPTH) are latched in AR_ACC.
- RD_MEM → R_RESP.
  - Synchronous memory read.
  - r_data is registered: memory word, or 0 when out of range.
- R_RESP → IDLE on r_ready; otherwise hold. r_data and r_resp stay stable while waiting.
- AW_ACC → W_WAIT. The address and error flag are latched in AW_ACC.
- W_WAIT → WR_MEM when w_valid. w_data and w_strb are latched on that handshake.
- WR_MEM → B_RESP.
  - Writes byte i of the word only where w_strb[i]=1.
  - Write suppressed when out of range.
- B_RESP → IDLE on b_ready; otherwise hold.
- Unreachable state encodings → IDLE.

Other rules:
- Response: SLVERR iff the latched error flag is set (see Configuration); otherwise OKAY.
- err_count: increments by 1 on each R or B handshake carrying SLVERR; saturates at 255.
- The block relies on AXI rules: ar_valid and aw_valid stay high until ready. The block never waits on a valid in AR_ACC or AW_ACC.

Reset (rst=1 at a clock edge):
- state=IDLE, last_grant=write (so the first contended grant goes to read).
- All ready/valid outputs 0; r_data=0; r_resp=b_resp=00; err_count=0.
- Memory contents are not reset.
- Reset in any state aborts the transaction. A write not yet in WR_MEM is never committed.

## Timing
- AR handshake at cycle T → r_valid rises at T+2. Minimum read transaction is 4 cycles from IDLE with ar_valid.
- AW handshake at T → w_ready=1 from T+1. W handshake at U ≥ T+1 → memory updated at the U+1 edge, b_valid at U+2.
- w_ready is 0 outside W_WAIT. W data presented earlier is not consumed until W_WAIT.
- Back-to-back: after a response handshake, the block returns to IDLE. It is ready for a new grant decision one cycle later.
- Read-after-write to the same address returns the new data; the write commits before B_RESP.

## Configuration
- Macro ERR_INJECT_EN.
- Defined: while force_err=1 when AR_ACC or AW_ACC is entered, the latched error flag is set regardless of address. Memory writes are still suppressed, and read data returns 0.
- Undefined: force_err is ignored (port still present, unconnected internally); errors come only from address decode.

## Test plan
- Write addr 3, data 0xDEADBEEF, strb 0xF; then read addr 3 → b_resp=00, then r_data=0xDEADBEEF, r_resp=00, r_valid at T+2 after AR handshake.
- Write 0xFFFFFFFF then write 0x00000000 with strb 0x5 to addr 2; read → 0xFF00FF00.
- ar_valid and aw_valid asserted together from reset, twice in a row → first grant read, second grant write (ar_ready precedes aw_ready).
- With DEPTH=16, ADDR_WDTH=8: write addr 20, then read addr 20 → both SLVERR, r_data=0, err_count=2. A subsequent read of addr 4 is unaffected.
- Hold r_ready=0 for 5 cycles → r_valid and r_data stable. Assert rst during W_WAIT → outputs 0 next cycle; target word unchanged.
- With ERR_INJECT_EN and force_err=1, read addr 1 → r_resp=10. Without the macro → r_resp=00.

Source files
------------

// File: rtl/axi_lite_mem_slave.sv
// axi_lite_mem_slave: AXI-Lite word-addressed memory slave.
// Serves one transaction at a time (AR->R or AW->W->B). Simultaneous AR/AW
// requests are arbitrated round-robin through a one-bit last_grant register.
// Out-of-range addresses get SLVERR; delivered SLVERR responses are counted
// in a saturating 8-bit counter.
// Optional feature macro: ERR_INJECT_EN. When defined, force_err sampled in
// AR_ACC/AW_ACC forces the transaction's error flag.
module axi_lite_mem_slave #(
  parameter int ADDR_WDTH = 8,
  parameter int DATA_WDTH = 32,
  parameter int DEPTH     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ar_valid,
  output logic                   ar_ready,
  input  logic [ADDR_WDTH-1:0]   ar_address,
  output logic                   r_valid,
  input  logic                   r_ready,
  output logic [DATA_WDTH-1:0]   r_data,
  output logic [1:0]             r_resp,
  input  logic                   aw_valid,
  output logic                   aw_ready,
  input  logic [ADDR_WDTH-1:0]   aw_address,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic [DATA_WDTH-1:0]   w_data,
  input  logic [DATA_WDTH/8-1:0] w_strb,
  output logic                   b_valid,
  input  logic                   b_ready,
  output logic [1:0]             b_resp,
  input  logic                   force_err,
  output logic [7:0]             err_count
);

  localparam int STRB_W = DATA_WDTH / 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // DEPTH may equal 2^ADDR_WDTH, so the limit needs one extra bit.
  localparam logic [ADDR_WDTH:0] DEPTH_LIM = (ADDR_WDTH + 1)'(DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE, AR_ACC, RD_MEM, R_RESP, AW_ACC, W_WAIT, WR_MEM, B_RESP
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  last_grant;   // 1 = write channel granted last
  logic [IDX_W-1:0]      idx_q;
  logic                  err_q;
  logic [DATA_WDTH-1:0]  wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  inject;
  logic                  rd_addr_err;
  logic                  wr_addr_err;
  logic                  err_handshake;

  logic [DATA_WDTH-1:0]  mem [DEPTH];

`ifdef ERR_INJECT_EN
  assign inject = force_err;
`else
  // force_err has no effect in this build; it is tied off here.
  logic unused_force_err;
  assign unused_force_err = force_err;
  assign inject           = 1'b0;
`endif

  assign rd_addr_err = ({1'b0, ar_address} >= DEPTH_LIM) | inject;
  assign wr_addr_err = ({1'b0, aw_address} >= DEPTH_LIM) | inject;

  // A response handshake carrying SLVERR bumps the error counter.
  assign err_handshake = err_q &&
                         (((state == R_RESP) && r_ready) ||
                          ((state == B_RESP) && b_ready));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic, including round-robin grant on contention.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned
    // (which would infer a latch).
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ar_valid && aw_valid) state_nxt = last_grant ? AR_ACC : AW_ACC;
        else if (ar_valid)        state_nxt = AR_ACC;
        else if (aw_valid)        state_nxt = AW_ACC;
      end
      AR_ACC: state_nxt = RD_MEM;
      RD_MEM: state_nxt = R_RESP;
      R_RESP: if (r_ready) state_nxt = IDLE;
      AW_ACC: state_nxt = W_WAIT;
      W_WAIT: if (w_valid) state_nxt = WR_MEM;
      WR_MEM: state_nxt = B_RESP;
      B_RESP: if (b_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs and response codes decoded from the current state.
  always_comb begin
    ar_ready = 1'b0;
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    r_valid  = 1'b0;
    b_valid  = 1'b0;
    r_resp   = RESP_OKAY;
    b_resp   = RESP_OKAY;
    case (state)
      AR_ACC: ar_ready = 1'b1;
      R_RESP: begin
        r_valid = 1'b1;
        r_resp  = err_q ? RESP_SLVERR : RESP_OKAY;
      end
      AW_ACC: aw_ready = 1'b1;
      W_WAIT: w_ready  = 1'b1;
      B_RESP: begin
        b_valid = 1'b1;
        b_resp  = err_q ? RESP_SLVERR : RESP_OKAY;
      end
      default: ;
    endcase
  end

  // Transaction datapath: grant history, latched address/error/write data,
  // registered read data and the saturating error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      idx_q      <= '0;
      err_q      <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      r_data     <= '0;
      err_count  <= 8'd0;
    end else begin
      if ((state == IDLE) && ar_valid && aw_valid)
        last_grant <= ~last_grant;

      case (state)
        AR_ACC: begin
          idx_q <= ar_address[IDX_W-1:0];
          err_q <= rd_addr_err;
        end
        AW_ACC: begin
          idx_q <= aw_address[IDX_W-1:0];
          err_q <= wr_addr_err;
        end
        W_WAIT: begin
          if (w_valid) begin
            wdata_q <= w_data;
            wstrb_q <= w_strb;
          end
        end
        RD_MEM: r_data <= err_q ? '0 : mem[idx_q];
        default: ;
      endcase

      if (err_handshake && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
    end
  end

  // Byte-masked memory write; suppressed for erroring transactions.
  always_ff @(posedge clk) begin
    // NOTE: the memory array is deliberately not reset so it maps onto plain
    // RAM; only control state is cleared by rst.
    if (!rst && (state == WR_MEM) && !err_q) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb_q[i]) mem[idx_q][i*8 +: 8] <= wdata_q[i*8 +: 8];
      end
    end
  end

endmodule
